// File: rtl/id_ex_skid_reg_if.sv
`default_nettype none
// =============================================================================
// Module  : id_ex_skid_reg_if
// Brief   : Decode-to-execute handshake, payload and counter bundle
// Revision: 1.0 - initial release
// =============================================================================
interface id_ex_skid_reg_if #(
    parameter int DATA_W  = 64,
    parameter int RD_W    = 2,
    parameter int ADDR_W  = 8,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic               flush;

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  rs_data_in;
    logic [DATA_W-1:0]  rt_data_in;
    logic [RD_W-1:0]    rd_in;
    logic [ADDR_W-1:0]  address_in;
    logic               WRegEn_in;
    logic               WMemEn_in;
    logic               MemToReg_in;
    logic [ALUOP_W-1:0] ALUOp_in;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  rs_data_out;
    logic [DATA_W-1:0]  rt_data_out;
    logic [RD_W-1:0]    rd_out;
    logic [ADDR_W-1:0]  address_out;
    logic               WRegEn_out;
    logic               WMemEn_out;
    logic               MemToReg_out;
    logic [ALUOP_W-1:0] ALUOp_out;

    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    // Pipeline-register side
    modport slave (
        input  flush,
        input  in_valid, rs_data_in, rt_data_in, rd_in, address_in,
        input  WRegEn_in, WMemEn_in, MemToReg_in, ALUOp_in,
        output in_ready,
        output out_valid, rs_data_out, rt_data_out, rd_out, address_out,
        output WRegEn_out, WMemEn_out, MemToReg_out, ALUOp_out,
        input  out_ready,
        output stall_cnt, flush_cnt
    );

    // Decode/execute environment side
    modport master (
        output flush,
        output in_valid, rs_data_in, rt_data_in, rd_in, address_in,
        output WRegEn_in, WMemEn_in, MemToReg_in, ALUOp_in,
        input  in_ready,
        input  out_valid, rs_data_out, rt_data_out, rd_out, address_out,
        input  WRegEn_out, WMemEn_out, MemToReg_out, ALUOp_out,
        output out_ready,
        input  stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// =============================================================================
// Module  : id_ex_skid_reg
// Brief   : ID/EX pipeline register with 2-entry skid buffer, flush and
//           bubble gating. Define ID_EX_PERF_CNT_EN to build stall/flush
//           performance counters; otherwise they read as zero.
// Revision: 1.0 - initial release
// =============================================================================
module id_ex_skid_reg #(
    parameter int DATA_W  = 64,
    parameter int RD_W    = 2,
    parameter int ADDR_W  = 8,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    id_ex_skid_reg_if.slave       bus
);

    typedef struct packed {
        logic [DATA_W-1:0]  rs;
        logic [DATA_W-1:0]  rt;
        logic [RD_W-1:0]    rd;
        logic [ADDR_W-1:0]  addr;
        logic               wreg;
        logic               wmem;
        logic               mem2reg;
        logic [ALUOP_W-1:0] aluop;
    } beat_t;

    beat_t in_beat;
    beat_t main_beat;
    beat_t skid_beat;
    logic  main_valid;
    logic  skid_valid;
    logic  in_ready;
    logic  accept;
    logic  drain;

    assign in_beat.rs      = bus.rs_data_in;
    assign in_beat.rt      = bus.rt_data_in;
    assign in_beat.rd      = bus.rd_in;
    assign in_beat.addr    = bus.address_in;
    assign in_beat.wreg    = bus.WRegEn_in;
    assign in_beat.wmem    = bus.WMemEn_in;
    assign in_beat.mem2reg = bus.MemToReg_in;
    assign in_beat.aluop   = bus.ALUOp_in;

    // in_ready depends only on skid occupancy, so out_ready never reaches it
    assign in_ready = ~skid_valid;
    assign accept   = bus.in_valid & in_ready & ~bus.flush;
    assign drain    = main_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_beat  <= '0;
            skid_beat  <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                main_beat  <= skid_beat;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || drain) begin
            main_valid <= accept;
            if (accept) begin
                main_beat <= in_beat;
            end
        end else if (accept) begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = main_valid;
    assign bus.rs_data_out  = main_beat.rs;
    assign bus.rt_data_out  = main_beat.rt;
    assign bus.rd_out       = main_beat.rd;
    assign bus.address_out  = main_beat.addr;
    assign bus.MemToReg_out = main_beat.mem2reg;
    assign bus.ALUOp_out    = main_beat.aluop;
    // Write enables are masked so stale data in an empty slot cannot commit
    assign bus.WRegEn_out   = main_beat.wreg & main_valid;
    assign bus.WMemEn_out   = main_beat.wmem & main_valid;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       flush_n;
    logic [CNT_W:0]   flush_sum;

    assign flush_n   = {1'b0, main_valid} + {1'b0, skid_valid}
                     + {1'b0, bus.in_valid & in_ready};
    assign flush_sum = {1'b0, flush_cnt} + {{(CNT_W-1){1'b0}}, flush_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !bus.out_ready && !bus.flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bus.flush) begin
                flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
            end
        end
    end

    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
`default_nettype none
// =============================================================================
// Module  : tb_id_ex_skid_reg
// Brief   : Directed self-checking bench for id_ex_skid_reg (CNT_W = 4)
// Revision: 1.0 - initial release
// =============================================================================
module tb_id_ex_skid_reg;

    localparam int CNT_W = 4;
`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_ex_skid_reg_if #(.CNT_W(CNT_W)) bus ();

    id_ex_skid_reg #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rt = ~rs, address = 0x40+rd, ALUOp = 5+rd, MemToReg = rd[0]
    task automatic set_beat(input logic v, input logic [1:0] rd, input logic [63:0] rs);
        bus.in_valid    = v;
        bus.rd_in       = rd;
        bus.rs_data_in  = rs;
        bus.rt_data_in  = ~rs;
        bus.address_in  = 8'h40 + {6'd0, rd};
        bus.WRegEn_in   = 1'b1;
        bus.WMemEn_in   = 1'b1;
        bus.MemToReg_in = rd[0];
        bus.ALUOp_in    = 4'd5 + {2'd0, rd};
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_beat(1'b0, 2'd0, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready",  bus.in_ready,    1);
        check("rst_out_valid", bus.out_valid,   0);
        check("rst_rs",        bus.rs_data_out, 0);
        check("rst_wreg",      bus.WRegEn_out,  0);
        check("rst_stall",     bus.stall_cnt,   0);
        check("rst_flush",     bus.flush_cnt,   0);

        // single beat, one-cycle latency
        bus.out_ready = 1'b1;
        set_beat(1'b1, 2'd2, 64'hA5A5_0000_0000_0001);
        tick();
        check("t1_valid", bus.out_valid,   1);
        check("t1_rs",    bus.rs_data_out, 64'hA5A5_0000_0000_0001);
        check("t1_rt",    bus.rt_data_out, 64'h5A5A_FFFF_FFFF_FFFE);
        check("t1_rd",    bus.rd_out,      2);
        check("t1_addr",  bus.address_out, 8'h42);
        check("t1_alu",   bus.ALUOp_out,   4'h7);
        check("t1_wreg",  bus.WRegEn_out,  1);
        set_beat(1'b0, 2'd0, 64'd0);
        tick();
        check("t1_drain", bus.out_valid, 0);

        // three beats under backpressure
        set_beat(1'b1, 2'd0, 64'h100);
        tick();
        bus.out_ready = 1'b0;
        set_beat(1'b1, 2'd1, 64'h101);
        tick();
        check("t2_main_rd", bus.rd_out,   0);
        check("t2_ready0",  bus.in_ready, 0);
        set_beat(1'b1, 2'd2, 64'h102);
        tick();
        check("t2_hold_rd", bus.rd_out,    0);
        check("t2_hold_rs", bus.rs_data_out, 64'h100);
        check("t2_ready1",  bus.in_ready,  0);
        check("t2_stall",   bus.stall_cnt, PERF ? 2 : 0);
        bus.out_ready = 1'b1;
        tick();
        check("t2_out1_rd", bus.rd_out,     1);
        check("t2_out1_rs", bus.rs_data_out, 64'h101);
        check("t2_out1_v",  bus.out_valid,  1);
        check("t2_ready2",  bus.in_ready,   1);
        tick();
        check("t2_out2_rd", bus.rd_out,     2);
        check("t2_out2_rs", bus.rs_data_out, 64'h102);
        check("t2_out2_m2r", bus.MemToReg_out, 0);
        set_beat(1'b0, 2'd0, 64'd0);
        tick();
        check("t2_empty", bus.out_valid, 0);

        // flush with main and skid full; incoming beat is blocked by in_ready=0
        bus.out_ready = 1'b0;
        set_beat(1'b1, 2'd1, 64'h201);
        tick();
        set_beat(1'b1, 2'd2, 64'h202);
        tick();
        check("t3_full", bus.in_ready, 0);
        set_beat(1'b1, 2'd3, 64'h203);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        set_beat(1'b0, 2'd0, 64'd0);
        check("t3_valid", bus.out_valid,  0);
        check("t3_wreg",  bus.WRegEn_out, 0);
        check("t3_wmem",  bus.WMemEn_out, 0);
        check("t3_ready", bus.in_ready,   1);
        check("t3_stale", bus.rd_out,     1);
        check("t3_fcnt",  bus.flush_cnt,  PERF ? 2 : 0);

        // flush with main full and an acceptable incoming beat
        set_beat(1'b1, 2'd0, 64'h300);
        tick();
        set_beat(1'b1, 2'd1, 64'h301);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        set_beat(1'b0, 2'd0, 64'd0);
        check("t3b_valid", bus.out_valid, 0);
        check("t3b_fcnt",  bus.flush_cnt, PERF ? 4 : 0);
        tick();
        check("t3b_stay", bus.out_valid, 0);

        // bubble between two beats
        bus.out_ready = 1'b1;
        set_beat(1'b1, 2'd1, 64'h401);
        tick();
        check("t4_v1",  bus.out_valid, 1);
        check("t4_rd1", bus.rd_out,    1);
        set_beat(1'b0, 2'd0, 64'd0);
        tick();
        check("t4_bub_v",    bus.out_valid,  0);
        check("t4_bub_wmem", bus.WMemEn_out, 0);
        set_beat(1'b1, 2'd2, 64'h402);
        tick();
        check("t4_v2",    bus.out_valid,  1);
        check("t4_rd2",   bus.rd_out,     2);
        check("t4_wmem2", bus.WMemEn_out, 1);
        set_beat(1'b0, 2'd0, 64'd0);
        tick();

        // long stall to saturate the stall counter
        bus.out_ready = 1'b0;
        set_beat(1'b1, 2'd3, 64'h503);
        tick();
        set_beat(1'b0, 2'd0, 64'd0);
        for (int i = 0; i < 20; i++) tick();
        check("t6_sat",   bus.stall_cnt, PERF ? 4'hF : 0);
        check("t6_rd",    bus.rd_out,    3);

        // reset while skid is full and execute is stalled
        set_beat(1'b1, 2'd1, 64'h601);
        tick();
        check("t5_skid", bus.in_ready, 0);
        set_beat(1'b0, 2'd0, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", bus.out_valid,   0);
        check("t5_ready", bus.in_ready,    1);
        check("t5_rs",    bus.rs_data_out, 0);
        check("t5_rd",    bus.rd_out,      0);
        check("t5_alu",   bus.ALUOp_out,   0);
        check("t5_wreg",  bus.WRegEn_out,  0);
        check("t5_stall", bus.stall_cnt,   0);
        check("t5_fcnt",  bus.flush_cnt,   0);
        tick();
        check("t5_noreplay", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
